ps2_key_buffer: RTL and testbench
=================================

# ps2_key_buffer

Parametrised PS/2 keyboard front end: receives raw PS/2 frames, checks them, tracks modifier state, converts make codes to ASCII and buffers characters in a show-ahead FIFO. It is the successor of the single-character keyboard path. It adds:
- frame error detection and a frame watchdog;
- E0/F0 prefix handling;
- shift and caps-lock tracking;
- configurable buffering with a read handshake, so the consumer no longer has to sample a one-cycle strobe.

## Interface
- `FIFO_DEPTH`, default 8: character FIFO entries; power of two, ≥2.
- `FILTER_LEN`, default 8: cycles `ps2_clk` must be stable before a level change is accepted.
- `TIMEOUT_CYCLES`, default 50000: idle cycles inside a frame before the frame is abandoned.
- `clk` input 1: system clock; the only clock.
- `reset` input 1: synchronous, active-high reset.
- `ps2_data` input 1: PS/2 data line, asynchronous.
- `ps2_clk` input 1: PS/2 clock line, asynchronous.
- `rd_en` input 1: pops the FIFO head when `char_valid`=1.
- `char_data` output 8: ASCII character at the FIFO head; 0x00 when empty.
- `char_valid` output 1: FIFO not empty.
- `fifo_count` output $clog2(FIFO_DEPTH+1): number of stored characters.
- `overflow` output 1: sticky flag; a character was dropped because the FIFO was full.
- `frame_err` output 1: one-cycle pulse on a parity, stop-bit or timeout error.
- `caps_lock` output 1: current caps-lock state.

## Operation
- Input conditioning: both PS/2 lines pass through 2-flop synchronisers. `ps2_clk` then goes through the `FILTER_LEN` stability filter. The falling edge of the filtered clock is the sample event.
- Frame FSM, clocked on sample events:
  - IDLE: start bit 0 → DATA; start bit 1 is ignored.
  - DATA: 8 data bits, LSB first → PARITY.
  - PARITY: parity bit sampled → STOP.
  - STOP: stop bit sampled → IDLE.
- Frame check: the frame is good only if it has odd parity over data+parity and stop bit = 1. A bad frame pulses `frame_err` and its byte is discarded.
- Watchdog: in any state other than IDLE, `TIMEOUT_CYCLES` cycles without a sample event → IDLE and pulse `frame_err`.
- Decoder, on each good byte:
  - 0xE0 sets `ext`; 0xF0 sets `brk`. Any other byte consumes both flags and clears them.
  - Shifts: 0x12 and 0x59 (not `ext`) set `shift_l`/`shift_r` on make and clear them on break.
  - Caps lock: 0x58 on make (not `brk`) toggles `caps_lock`. Auto-repeat makes toggle it again; this is intended.
  - Character output: only non-`brk`, non-`ext` make codes of mapped keys produce a character.
- ASCII map:
  - Letters 'a'..'z' → 0x61..0x7A; uppercase 0x41..0x5A when (`shift_l`|`shift_r`) XOR `caps_lock`.
  - Digits 0..9 → 0x30..0x39, unaffected by modifiers.
  - Space 0x29 → 0x20; Enter 0x5A → 0x0D; Backspace 0x66 → 0x08.
  - Unmapped codes are dropped silently.
- FIFO:
  - Write when a character is produced and the FIFO is not full.
  - Pop when `rd_en`=1 and `char_valid`=1; `rd_en` while empty is ignored.
  - Write while full and no pop: the new character is dropped and `overflow` is set. `overflow` clears only on reset.
  - Simultaneous pop and write while full: both occur; `fifo_count` is unchanged and `overflow` is not set.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Reset, including mid-frame: frame FSM → IDLE, bit counter 0, `ext`/`brk`/shift/`caps_lock` = 0, FIFO emptied. Outputs take these values: `char_data`=0x00, `char_valid`=0, `fifo_count`=0, `overflow`=0, `frame_err`=0, `caps_lock`=0. A partially received frame is lost. The filter restarts from the current line level.

## Timing
- Edge-detect latency: ~2 (sync) + `FILTER_LEN` + 1 cycles from the pin transition.
- Let the stop-bit sample event occur in cycle N:
  - `frame_err` pulses in cycle N+1 if the frame is bad.
  - A good byte is decoded in cycle N+1 and the FIFO write occurs on the N+1 edge.
  - `char_valid`, `char_data` and `fifo_count` reflect the new entry in cycle N+2.
- `rd_en` asserted in cycle M with `char_valid`=1 → next entry, or empty, visible in cycle M+1.
- At most one character is written per frame; there are no back-to-back writes in consecutive cycles.

## Structure
- Package `ps2_pkg`:
  - scan-code constants: E0, F0, shift L/R, caps, space, enter, backspace;
  - ASCII constants;
  - frame FSM state enum;
  - the pure function `scan_to_ascii(code, upper)`, which returns an 8-bit code with 0x00 meaning unmapped.
- Sub-module `ps2_rx_frame`: synchronisers, filter, frame FSM and watchdog. Outputs `byte_valid` and `byte_data`, plus an error pulse.
- The top level holds the decoder state and the FIFO.

## Test plan
- Frames 0x1C, then 0xF0 0x1C → one entry 0x61 'a', `fifo_count`=1; the break code adds nothing.
- 0x12, 0x1C, 0xF0 0x12, 0x1C → entries 0x41, 0x61. Then 0x58, 0x1C → 0x41 and `caps_lock`=1.
- Frame 0x1C with bad parity → `frame_err` pulses, no entry. A frame stopped after 4 bits → `frame_err` after `TIMEOUT_CYCLES`, and the next good frame is received correctly.
- `FIFO_DEPTH`+1 make codes with no reads → `fifo_count`=`FIFO_DEPTH`, `overflow`=1, head is the first character. Write coinciding with `rd_en` while full → no overflow.
- 0xE0 0x1C → no entry. `rd_en` while empty → `fifo_count` stays 0.
- `reset` asserted mid-frame with 3 entries stored → all outputs at reset values the next cycle; the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: scan codes, ASCII codes, frame states and
// the scan-code to ASCII translation used by the key buffer.
package ps2_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_CAPS    = 8'h58;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_BKSP    = 8'h66;

  localparam logic [7:0] ASCII_NUL  = 8'h00;
  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;
  localparam logic [7:0] ASCII_CASE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  // Set-2 make code to ASCII; returns ASCII_NUL for unmapped codes.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] ch;
    ch = ASCII_NUL;
    case (code)
      8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
      8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
      8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
      8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
      8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
      8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
      8'h35: ch = "y";  8'h1A: ch = "z";
      8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";  8'h26: ch = "3";
      8'h25: ch = "4";  8'h2E: ch = "5";  8'h36: ch = "6";  8'h3D: ch = "7";
      8'h3E: ch = "8";  8'h46: ch = "9";
      SC_SPACE: ch = ASCII_SP;
      SC_ENTER: ch = ASCII_CR;
      SC_BKSP:  ch = ASCII_BS;
      default:  ch = ASCII_NUL;
    endcase
    if (upper && ch >= ASCII_LC_A && ch <= ASCII_LC_Z) ch = ch - ASCII_CASE;
    return ch;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: line synchronisers, clock glitch filter, 11-bit frame
// FSM with parity/stop checking and an in-frame watchdog.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          sample_evt;
  logic          sample_bit;
  frame_state_e  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    clk_sync  <= {clk_sync[0], ps2_clk};
    data_sync <= {data_sync[0], ps2_data};
  end

  // A new clock level is accepted only after it has held for FILTER_LEN cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_clk   <= clk_sync[1];
      filt_cnt   <= '0;
      sample_evt <= 1'b0;
      sample_bit <= 1'b1;
    end else begin
      sample_evt <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk   <= clk_sync[1];
        filt_cnt   <= '0;
        sample_evt <= filt_clk;
        sample_bit <= data_sync[1];
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      wd_cnt     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == ST_IDLE || sample_evt) wd_cnt <= '0;
      else                                wd_cnt <= wd_cnt + TW'(1);

      if (state != ST_IDLE && !sample_evt && wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end else if (sample_evt) begin
        case (state)
          ST_IDLE: begin
            if (!sample_bit) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shreg   <= {sample_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= sample_bit;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state     <= ST_IDLE;
            byte_data <= shreg;
            if ((^{shreg, par_bit}) && sample_bit) byte_valid <= 1'b1;
            else                                   frame_err  <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_buffer.sv
// PS/2 keyboard front end: frame receiver, modifier tracking, ASCII
// translation and a show-ahead character FIFO with read handshake.
module ps2_key_buffer
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ps2_data,
  input  logic                              ps2_clk,
  input  logic                              rd_en,
  output logic [7:0]                        char_data,
  output logic                              char_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              frame_err,
  output logic                              caps_lock
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          ext;
  logic          brk;
  logic          shift_l;
  logic          shift_r;
  logic [7:0]    ascii_c;
  logic          wr_c;
  logic          full_c;
  logic          pop_c;
  logic          push_c;
  logic [CW-1:0] next_count_c;
  logic [AW-1:0] next_rd_c;
  logic [7:0]    next_head_c;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Prefix bytes only arm flags; every other byte consumes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps_lock <= 1'b0;
    end else if (byte_valid) begin
      if (byte_data == SC_EXT) begin
        ext <= 1'b1;
      end else if (byte_data == SC_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (!ext && byte_data == SC_SHIFT_L) shift_l <= !brk;
        if (!ext && byte_data == SC_SHIFT_R) shift_r <= !brk;
        if (!brk && byte_data == SC_CAPS)    caps_lock <= !caps_lock;
      end
    end
  end

  // Head is precomputed so char_data is registered and shows the entry that
  // will be at the front after this cycle's push/pop.
  always_comb begin
    ascii_c = ASCII_NUL;
    if (byte_valid && !ext && !brk)
      ascii_c = scan_to_ascii(byte_data, (shift_l | shift_r) ^ caps_lock);
    wr_c         = (ascii_c != ASCII_NUL);
    full_c       = (fifo_count == CW'(FIFO_DEPTH));
    pop_c        = rd_en && char_valid;
    push_c       = wr_c && (!full_c || pop_c);
    next_count_c = fifo_count + CW'(push_c) - CW'(pop_c);
    next_rd_c    = rd_ptr + AW'(pop_c);
    if (next_count_c == '0)                 next_head_c = ASCII_NUL;
    else if (push_c && wr_ptr == next_rd_c) next_head_c = ascii_c;
    else                                    next_head_c = mem[next_rd_c];
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= ascii_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      char_valid <= 1'b0;
      char_data  <= ASCII_NUL;
      overflow   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= next_rd_c;
      fifo_count <= next_count_c;
      char_valid <= (next_count_c != '0);
      char_data  <= next_head_c;
      if (wr_c && full_c && !pop_c) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Scoreboard bench for ps2_key_buffer: PS/2 frames driven from a task, a
// queue-based keyboard model predicts FIFO contents, a monitor checks pops.
module tb_ps2_key_buffer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned FILT    = 4;
  localparam int unsigned TIMEOUT = 2000;
  localparam int unsigned HALF    = 12;
  localparam int unsigned CW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          ps2_data;
  logic          ps2_clk;
  logic          rd_en;
  logic [7:0]    char_data;
  logic          char_valid;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          frame_err;
  logic          caps_lock;

  ps2_key_buffer #(
    .FIFO_DEPTH    (DEPTH),
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_data  (ps2_data),
    .ps2_clk   (ps2_clk),
    .rd_en     (rd_en),
    .char_data (char_data),
    .char_valid(char_valid),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .caps_lock (caps_lock)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int exp_err  = 0;

  logic [7:0] exp_q[$];
  bit m_ext, m_brk, m_shl, m_shr, m_caps, m_ovf;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                   8'h3D, 8'h3E, 8'h46};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_ascii(input logic [7:0] b, input bit upper);
    for (int i = 0; i < 26; i++)
      if (b == letter_codes[i]) return upper ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++)
      if (b == digit_codes[i]) return 8'(48 + i);
    if (b == 8'h29) return 8'h20;
    if (b == 8'h5A) return 8'h0D;
    if (b == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  // Keyboard behaviour for one good byte, applied after the DUT has written.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] c;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      c = (m_ext || m_brk) ? 8'h00 : model_ascii(b, (m_shl || m_shr) != m_caps);
      if (!m_ext && b == 8'h12) m_shl = !m_brk;
      if (!m_ext && b == 8'h59) m_shr = !m_brk;
      if (!m_brk && b == 8'h58) m_caps = !m_caps;
      m_ext = 0;
      m_brk = 0;
      if (c != 8'h00) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(c);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_ovf = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] bits;
    bits = {!bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 0, 0, 11);
    wait_cyc(20);
    model_byte(b);
  endtask

  task automatic bad_key(input logic [7:0] b, input bit bad_stop);
    send_frame(b, !bad_stop, bad_stop, 11);
    wait_cyc(20);
    exp_err++;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
    wait_cyc(1);
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    repeat (n) pop_one();
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(fifo_count), exp_q.size());
    chk({tag, ".valid"}, 32'(char_valid), (exp_q.size() != 0) ? 1 : 0);
    chk({tag, ".head"},  32'(char_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 0);
    chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    chk({tag, ".caps"},  32'(caps_lock), 32'(m_caps));
    chk({tag, ".errs"},  err_seen, exp_err);
  endtask

  // Good frame whose FIFO write lands in the same cycle as a pop.
  task automatic key_with_pop(input logic [7:0] b);
    bit seen;
    seen = 0;
    fork
      send_frame(b, 0, 0, 11);
      begin
        for (int i = 0; i < 1000 && !seen; i++) begin
          wait_cyc(1);
          if (dut.u_rx.byte_valid) seen = 1;
        end
        if (seen) begin
          rd_en = 1'b1;
          wait_cyc(1);
          rd_en = 1'b0;
        end
      end
    join
    chk("simul.byte_seen", 32'(seen), 1);
    wait_cyc(20);
    model_byte(b);
  endtask

  // Monitor: every accepted pop must match the oldest predicted character.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) err_seen++;
      if (rd_en && char_valid) begin
        if (exp_q.size() == 0) chk("pop.unexpected", 32'(char_valid), 0);
        else chk("pop.data", 32'(char_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] b;
    int r;
    reset = 1'b1; rd_en = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_reset();
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    check_state("reset");

    key(8'h1C); key(8'hF0); key(8'h1C);
    check_state("make_break");
    drain();

    key(8'h12); key(8'h1C); key(8'hF0); key(8'h12); key(8'h1C);
    check_state("shift");
    drain();
    key(8'h58); key(8'h1C);
    check_state("caps");
    drain();

    bad_key(8'h1C, 0);
    check_state("bad_parity");
    bad_key(8'h1C, 1);
    check_state("bad_stop");
    send_frame(8'h1C, 0, 0, 5);
    wait_cyc(TIMEOUT + 100);
    exp_err++;
    check_state("timeout");
    key(8'h32);
    check_state("after_timeout");
    drain();

    key(8'hE0); key(8'h1C);
    check_state("ext");
    pop_one();
    check_state("rd_empty");

    key(8'h1C); key(8'h32); key(8'h21); key(8'h23);
    check_state("full");
    key_with_pop(8'h24);
    check_state("full_pop_write");
    key(8'h2B);
    check_state("overflow");
    drain();

    key(8'h1C); key(8'h45); key(8'h29);
    send_frame(8'h32, 0, 0, 5);
    reset = 1'b1;
    wait_cyc(1);
    chk("rst.char_data", 32'(char_data), 0);
    chk("rst.char_valid", 32'(char_valid), 0);
    chk("rst.fifo_count", 32'(fifo_count), 0);
    chk("rst.overflow", 32'(overflow), 0);
    chk("rst.frame_err", 32'(frame_err), 0);
    chk("rst.caps_lock", 32'(caps_lock), 0);
    reset = 1'b0;
    model_reset();
    wait_cyc(5);
    key(8'h1C);
    check_state("after_reset");
    drain();

    for (int it = 0; it < 50; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: b = letter_codes[$urandom_range(0, 25)];
        4:          b = digit_codes[$urandom_range(0, 9)];
        5:          b = $urandom_range(0, 1) ? 8'h12 : 8'h59;
        6:          b = 8'h58;
        7:          b = $urandom_range(0, 1) ? 8'hE0 : 8'hF0;
        8:          b = $urandom_range(0, 1) ? 8'h29 : ($urandom_range(0, 1) ? 8'h5A : 8'h66);
        default:    b = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) bad_key(b, $urandom_range(0, 1));
      else key(b);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 3)) pop_one();
      check_state("random");
    end
    drain();
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
